// File: rtl/sw_debounce_pkg.sv
// Shared helpers for the switch debouncer: width calculation for counters
// whose range may collapse to a single value.
package sw_debounce_pkg;

    // Bits needed to hold 0..n-1, never less than one so that a
    // degenerate range (n == 1) still yields a legal vector.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounce channel: stability counter, accepted level and edge pulses.
// The input is already synchronised; the counter only advances on prescaler
// ticks and is cleared on any cycle where the input agrees with the output.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_TICKS = 10,
    parameter logic RESET_BIT      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_sync,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int            CW   = clog2_min1(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [CW-1:0] r_cnt;
    logic          r_clean;
    logic          r_rise;
    logic          r_fall;

    logic w_diff;
    logic w_accept;

    // Disagreement with the accepted level; acceptance on the final tick.
    always_comb begin
        w_diff   = i_sync ^ r_clean;
        w_accept = w_diff & i_tick & (r_cnt == LAST);
    end

    // Counter, accepted level and one-cycle pulses. The counter saturates at
    // LAST by construction: reaching it with a tick always accepts and clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_clean <= RESET_BIT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_accept &  i_sync;
            r_fall <= w_accept & ~i_sync;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == LAST) begin
                    r_clean <= i_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_clean  = r_clean;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch/button debouncer. Two-flop synchroniser per channel,
// one shared tick prescaler, and an array of per-channel debounce cells.
// clean_out feeds a PIO edge-capture input, so each physical transition must
// produce exactly one level change here.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               TICK_DIV       = 50000,
    parameter int               DEBOUNCE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int            PW     = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [PW-1:0]    r_pcnt;
    logic             r_any;

    logic             w_tick;
    logic [WIDTH-1:0] w_accept;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
        end
    end

    // Tick fires on the last count; with TICK_DIV == 1 it is always high.
    always_comb begin
        w_tick = (r_pcnt == P_LAST);
    end

    // Free-running prescaler, wraps to zero on the tick cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sw_debounce_bit #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .RESET_BIT      (RESET_VAL[i])
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .i_tick   (w_tick),
            .i_sync   (r_s2[i]),
            .o_clean  (clean_out[i]),
            .o_rise   (rise_pulse[i]),
            .o_fall   (fall_pulse[i]),
            .o_accept (w_accept[i])
        );
    end

    // Registered from the acceptance strobes so it lines up with the pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_accept;
        end
    end

    assign any_change = r_any;

endmodule
